sevenseg_reader: RTL and testbench

- Reverse-direction companion to the sevenseg hex-to-segment decoder. It watches a 7-bit segment bus, waits until the pattern has been stable for a set number of cycles, and decodes it back to a 4-bit hex digit.
- It flags blank patterns and illegal patterns, and keeps a saturating error count.
- Used in self-checking benches and on-board loopback checks of the HEX display path.

---
 rtl/sevenseg_reader.sv | 155 +++++++++++++++
 tb/tb_sevenseg_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_reader.sv
// Decodes a debounced 7-segment bus back to a hex digit, flagging blank and illegal patterns.
// Commit lands STABLE_CYCLES enabled edges after a new pattern is sampled; no backpressure, en only freezes.
module sevenseg_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int ERR_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [6:0]       segments,
  input  logic             err_clr,
  output logic [3:0]       digit,
  output logic             blank,
  output logic             locked,
  output logic             valid,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {TRACK, HOLD} state_t;

  state_t           state_q, state_d;
  logic [6:0]       p;
  logic [6:0]       cand_q, cand_d;
  logic [6:0]       comm_q, comm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             have_comm_q, have_comm_d;
  logic [3:0]       digit_q, digit_d;
  logic             blank_q, blank_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             commit;
  logic             dec_legal;
  logic             dec_blank;
  logic [3:0]       dec_val;

  assign p = ACTIVE_LOW ? ~segments : segments;

  always_ff @(posedge clk) begin
    if (reset) state_q <= TRACK;
    else       state_q <= state_d;
  end

  // Any change of the sampled pattern restarts the stability count, from either state.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (en) begin
      if (p != cand_q) begin
        cand_d  = p;
        cnt_d   = '0;
        state_d = TRACK;
      end else if (state_q == TRACK) begin
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!have_comm_q || cand_q != comm_q) begin
          commit  = 1'b1;
          state_d = HOLD;
        end
      end
    end
  end

  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_val   = 4'h0;
    case (cand_q)
      7'h3F: dec_val = 4'h0;
      7'h06: dec_val = 4'h1;
      7'h5B: dec_val = 4'h2;
      7'h4F: dec_val = 4'h3;
      7'h66: dec_val = 4'h4;
      7'h6D: dec_val = 4'h5;
      7'h7D: dec_val = 4'h6;
      7'h07: dec_val = 4'h7;
      7'h7F: dec_val = 4'h8;
      7'h6F: dec_val = 4'h9;
      7'h77: dec_val = 4'hA;
      7'h7C: dec_val = 4'hB;
      7'h39: dec_val = 4'hC;
      7'h5E: dec_val = 4'hD;
      7'h79: dec_val = 4'hE;
      7'h71: dec_val = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    comm_d      = comm_q;
    have_comm_d = have_comm_q;
    digit_d     = digit_q;
    blank_d     = blank_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    if (commit) begin
      comm_d      = cand_q;
      have_comm_d = 1'b1;
      if (dec_blank) begin
        blank_d = 1'b1;
        valid_d = 1'b1;
      end else if (dec_legal) begin
        digit_d = dec_val;
        blank_d = 1'b0;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
      end
    end
    // Clear takes priority over a coincident increment; the err pulse still goes out.
    if (err_clr) err_count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q      <= '0;
      cnt_q       <= '0;
      comm_q      <= '0;
      have_comm_q <= 1'b0;
      digit_q     <= 4'h0;
      blank_q     <= 1'b1;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      comm_q      <= comm_d;
      have_comm_q <= have_comm_d;
      digit_q     <= digit_d;
      blank_q     <= blank_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign digit     = digit_q;
  assign blank     = blank_q;
  assign locked    = have_comm_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Bench for sevenseg_reader (ACTIVE_LOW=1, STABLE_CYCLES=4): expected commit events are queued
// with the cycle they must appear in, and a negedge monitor matches every valid/err pulse against them.
module tb_sevenseg_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [6:0]  segments;
  logic        err_clr;
  logic [3:0]  digit;
  logic        blank;
  logic        locked;
  logic        valid;
  logic        err;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [3:0]  digit;
    logic        blank;
    logic [15:0] ec;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0]  m_digit;
  logic        m_blank;
  logic [15:0] m_ec;

  logic [6:0] lit_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  sevenseg_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .segments(segments), .err_clr(err_clr),
    .digit(digit), .blank(blank), .locked(locked), .valid(valid), .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_event: no pulse by cycle %0d, required at cycle %0d (err=%0b digit=%0h)",
               cyc, exp_q[0].cyc, exp_q[0].is_err, exp_q[0].digit);
      void'(exp_q.pop_front());
    end
    if (valid || err) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: cycle %0d valid=%0b err=%0b digit=%0h, required no pulse",
                 cyc, valid, err, digit);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || valid !== !e.is_err || err !== e.is_err || digit !== e.digit ||
            blank !== e.blank || err_count !== e.ec) begin
          failures++;
          $display("FAIL event: got cyc=%0d valid=%0b err=%0b digit=%0h blank=%0b ec=%0d, required cyc=%0d valid=%0b err=%0b digit=%0h blank=%0b ec=%0d",
                   cyc, valid, err, digit, blank, err_count,
                   e.cyc, !e.is_err, e.is_err, e.digit, e.blank, e.ec);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] al(input int d);
    logic [6:0] v;
    v = lit_tbl[d];
    return ~v;
  endfunction

  task automatic model_reset();
    m_digit = 4'h0;
    m_blank = 1'b1;
    m_ec    = 16'd0;
  endtask

  // kind: 0 = legal digit d, 1 = blank, 2 = illegal
  task automatic push_event(input int dly, input int kind, input logic [3:0] d);
    exp_t e;
    if (kind == 0) begin m_digit = d; m_blank = 1'b0; end
    else if (kind == 1) m_blank = 1'b1;
    else if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
    e.cyc = cyc + dly; e.is_err = (kind == 2); e.digit = m_digit; e.blank = m_blank; e.ec = m_ec;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; err_clr = 1'b0; segments = 7'h7F;
    model_reset();
    step(3);
    checks++; if (digit !== 4'h0)      begin failures++; $display("FAIL reset_digit: got %0h, required 0", digit); end
    checks++; if (blank !== 1'b1)      begin failures++; $display("FAIL reset_blank: got %0b, required 1", blank); end
    checks++; if (locked !== 1'b0)     begin failures++; $display("FAIL reset_locked: got %0b, required 0", locked); end
    checks++; if (valid !== 1'b0)      begin failures++; $display("FAIL reset_valid: got %0b, required 0", valid); end
    checks++; if (err !== 1'b0)        begin failures++; $display("FAIL reset_err: got %0b, required 0", err); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count: got %0d, required 0", err_count); end
  endtask

  task automatic test_first_commit();
    segments = 7'h40;
    reset    = 1'b0;
    push_event(5, 0, 4'h0);
    step(25);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL first_locked: got %0b, required 1", locked); end
    checks++; if (digit !== 4'h0 || blank !== 1'b0)
      begin failures++; $display("FAIL first_digit: got digit=%0h blank=%0b, required 0/0", digit, blank); end
  endtask

  task automatic test_sweep();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    model_reset();
    for (int d = 0; d < 16; d++) begin
      segments = al(d);
      push_event(5, 0, 4'(d));
      step(6);
    end
    step(1);
    checks++; if (digit !== 4'hF)      begin failures++; $display("FAIL sweep_last_digit: got %0h, required F", digit); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL sweep_err_count: got %0d, required 0", err_count); end
  endtask

  task automatic test_glitch();
    segments = al(1);
    push_event(5, 0, 4'h1);
    step(8);
    segments = 7'h12;
    step(2);
    segments = al(1);
    step(12);
    checks++; if (digit !== 4'h1) begin failures++; $display("FAIL glitch_digit: got %0h, required 1", digit); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL glitch_queue: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 3; i++) begin
      segments = 7'h7E;
      push_event(5, 2, 4'h0);
      step(5);
      segments = 7'h40;
      push_event(5, 0, 4'h0);
      step(5);
    end
    step(1);
    checks++; if (err_count !== 16'd3) begin failures++; $display("FAIL illegal_count: got %0d, required 3", err_count); end
    checks++; if (digit !== 4'h0)      begin failures++; $display("FAIL illegal_digit: got %0h, required 0", digit); end
    segments = 7'h7E;
    push_event(5, 2, 4'h0);
    m_ec = 16'd0;
    exp_q[exp_q.size()-1].ec = 16'd0;
    step(4);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(3);
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL clear_wins: got %0d, required 0", err_count); end
  endtask

  task automatic test_enable();
    segments = al(1);
    push_event(15, 0, 4'h1);
    step(3);
    en = 1'b0;
    step(10);
    en = 1'b1;
    step(5);
    checks++; if (digit !== 4'h1) begin failures++; $display("FAIL enable_digit: got %0h, required 1", digit); end
  endtask

  task automatic test_reset_midcount();
    segments = 7'h12;
    step(2);
    reset    = 1'b1;
    segments = 7'h7F;
    step(1);
    reset = 1'b0;
    model_reset();
    checks++; if (blank !== 1'b1 || locked !== 1'b0 || digit !== 4'h0)
      begin failures++; $display("FAIL midreset_state: got blank=%0b locked=%0b digit=%0h, required 1/0/0", blank, locked, digit); end
    push_event(4, 1, 4'h0);
    step(6);
    checks++; if (blank !== 1'b1 || locked !== 1'b1)
      begin failures++; $display("FAIL midreset_commit: got blank=%0b locked=%0b, required 1/1", blank, locked); end
  endtask

  initial begin
    test_reset();
    test_first_commit();
    test_sweep();
    test_glitch();
    test_illegal();
    test_enable();
    test_reset_midcount();
    step(2);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
